// File: rtl/hamming_pkg.sv
// hamming_pkg: shared widths and FSM state type for the Hamming(7,4) link controller
package hamming_pkg;
    localparam int POS_W  = 3;
    localparam int CODE_W = 7;
    localparam int DATA_W = 4;
    typedef enum logic [1:0] {IDLE, INJ, DEC, OUT} state_t;
endpackage

// File: rtl/hamming74_codec.sv
// hamming74_codec: combinational Hamming(7,4) encoder plus syndrome/correct/extract decoder
//   enc_data -> enc_code          : code[0..6] = positions 1..7 = p1,p2,d0,p4,d1,d2,d3, even parity
//   dec_code -> dec_syndrome      : binary index of the erroneous position, 0 = clean
//   dec_code -> dec_data          : data bits after single-bit correction
module hamming74_codec import hamming_pkg::*; (
    input  logic [DATA_W-1:0] enc_data,
    output logic [CODE_W-1:0] enc_code,
    input  logic [CODE_W-1:0] dec_code,
    output logic [POS_W-1:0]  dec_syndrome,
    output logic [DATA_W-1:0] dec_data
);
    logic [CODE_W-1:0] fixed;
    assign enc_code = {enc_data[3], enc_data[2], enc_data[1],
                       enc_data[1] ^ enc_data[2] ^ enc_data[3],
                       enc_data[0],
                       enc_data[0] ^ enc_data[2] ^ enc_data[3],
                       enc_data[0] ^ enc_data[1] ^ enc_data[3]};
    assign dec_syndrome = {dec_code[3] ^ dec_code[4] ^ dec_code[5] ^ dec_code[6],
                           dec_code[1] ^ dec_code[2] ^ dec_code[5] ^ dec_code[6],
                           dec_code[0] ^ dec_code[2] ^ dec_code[4] ^ dec_code[6]};
    assign fixed = dec_code ^ ((dec_syndrome == '0) ? '0 : CODE_W'(1) << (dec_syndrome - 3'd1));
    assign dec_data = {fixed[6], fixed[5], fixed[4], fixed[2]};
endmodule

// File: rtl/hamming_link_controller.sv
// hamming_link_controller: encode -> inject single-bit error -> decode/correct pipeline FSM with statistics
//   in_valid/in_ready/in_data, inject_en, err_pos : source side, sampled on acceptance
//   out_valid/out_ready, out_data/out_code/out_syndrome/out_mismatch : sink side, held until handshake
//   word_cnt/corr_cnt/err_cnt, clr_cnt : saturating statistics, synchronous clear
//   busy : high outside IDLE
module hamming_link_controller import hamming_pkg::*; #(
    parameter int CNT_W    = 16,
    parameter bit AUTO_POS = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              inject_en,
    input  logic [POS_W-1:0]  err_pos,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CODE_W-1:0] out_code,
    output logic [POS_W-1:0]  out_syndrome,
    output logic              out_mismatch,
    output logic [CNT_W-1:0]  word_cnt,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    input  logic              clr_cnt,
    output logic              busy
);
    state_t            state;
    logic [DATA_W-1:0] data_q, dec_data;
    logic [CODE_W-1:0] code_q, enc_code, flip;
    logic [POS_W-1:0]  pos_q, auto_pos, syn;
    logic              inj_q;
    logic              accept, done;

    assign in_ready  = state == IDLE;
    assign out_valid = state == OUT;
    assign busy      = state != IDLE;
    assign accept    = in_valid && in_ready;
    assign done      = out_valid && out_ready;
    assign flip      = (inj_q && pos_q != '0) ? CODE_W'(1) << (pos_q - 3'd1) : '0;

    hamming74_codec u_codec (
        .enc_data     (in_data),
        .enc_code     (enc_code),
        .dec_code     (code_q),
        .dec_syndrome (syn),
        .dec_data     (dec_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            data_q       <= '0;
            code_q       <= '0;
            pos_q        <= '0;
            inj_q        <= 1'b0;
            auto_pos     <= 3'd1;
            out_data     <= '0;
            out_code     <= '0;
            out_syndrome <= '0;
            out_mismatch <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    data_q <= in_data;
                    inj_q  <= inject_en;
                    pos_q  <= AUTO_POS ? auto_pos : err_pos;
                    code_q <= enc_code;
                    state  <= INJ;
                    // the rotating position only moves when it was actually consumed
                    if (AUTO_POS && inject_en)
                        auto_pos <= (auto_pos == 3'd7) ? 3'd1 : auto_pos + 3'd1;
                end
                INJ: begin
                    code_q <= code_q ^ flip;
                    state  <= DEC;
                end
                DEC: begin
                    out_code     <= code_q;
                    out_syndrome <= syn;
                    out_data     <= dec_data;
                    out_mismatch <= dec_data != data_q;
                    state        <= OUT;
                end
                OUT: if (done) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // increment terms are masked to zero once a counter reaches all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || clr_cnt) begin
            word_cnt <= '0;
            corr_cnt <= '0;
            err_cnt  <= '0;
        end else if (done) begin
            word_cnt <= word_cnt + CNT_W'(~&word_cnt);
            corr_cnt <= corr_cnt + CNT_W'(out_syndrome != '0 && ~&corr_cnt);
            err_cnt  <= err_cnt + CNT_W'(out_mismatch && ~&err_cnt);
        end
    end
endmodule

// File: tb/tb_hamming_link_controller.sv
// tb_hamming_link_controller: table-driven, random and corner-case checks of hamming_link_controller
module tb_hamming_link_controller;
    logic        clk = 1'b0;
    logic        rst_n, rst_a_n, in_valid, inject_en, out_ready, clr_cnt, sel;
    logic [3:0]  in_data;
    logic [2:0]  err_pos;
    logic        in_ready, out_valid, busy, out_mismatch;
    logic [3:0]  out_data;
    logic [6:0]  out_code;
    logic [2:0]  out_syndrome;
    logic [15:0] word_cnt, corr_cnt, err_cnt;
    logic        a_in_ready, a_out_valid, a_busy, a_out_mismatch;
    logic [3:0]  a_out_data;
    logic [6:0]  a_out_code;
    logic [2:0]  a_out_syndrome;
    logic [2:0]  a_word_cnt, a_corr_cnt, a_err_cnt;
    logic        cur_ready, cur_valid, cur_busy, cur_mm;
    logic [3:0]  cur_data;
    logic [6:0]  cur_code;
    logic [2:0]  cur_syn;
    logic [15:0] cur_word, cur_corr, cur_err;
    int          passed = 0, total = 0;
    int          ew, ec, ee, emax;

    typedef struct {
        logic [3:0] d;
        logic       inj;
        logic [2:0] p;
        int         hold;
        logic       kv;
        logic [6:0] code;
        logic [2:0] syn;
    } vec_t;
    vec_t vt [5];

    always #5 clk = ~clk;

    hamming_link_controller #(.CNT_W(16), .AUTO_POS(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .inject_en(inject_en), .err_pos(err_pos), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_code(out_code), .out_syndrome(out_syndrome),
        .out_mismatch(out_mismatch), .word_cnt(word_cnt), .corr_cnt(corr_cnt), .err_cnt(err_cnt),
        .clr_cnt(clr_cnt), .busy(busy)
    );

    hamming_link_controller #(.CNT_W(3), .AUTO_POS(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .inject_en(inject_en), .err_pos(err_pos), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_data(a_out_data), .out_code(a_out_code), .out_syndrome(a_out_syndrome),
        .out_mismatch(a_out_mismatch), .word_cnt(a_word_cnt), .corr_cnt(a_corr_cnt),
        .err_cnt(a_err_cnt), .clr_cnt(clr_cnt), .busy(a_busy)
    );

    assign cur_ready = sel ? a_in_ready : in_ready;
    assign cur_valid = sel ? a_out_valid : out_valid;
    assign cur_busy  = sel ? a_busy : busy;
    assign cur_mm    = sel ? a_out_mismatch : out_mismatch;
    assign cur_data  = sel ? a_out_data : out_data;
    assign cur_code  = sel ? a_out_code : out_code;
    assign cur_syn   = sel ? a_out_syndrome : out_syndrome;
    assign cur_word  = sel ? {13'd0, a_word_cnt} : word_cnt;
    assign cur_corr  = sel ? {13'd0, a_corr_cnt} : corr_cnt;
    assign cur_err   = sel ? {13'd0, a_err_cnt} : err_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Textbook Hamming construction: data at non-power-of-two positions,
    // parity at position p covers every data position whose index has bit p set.
    function automatic logic [6:0] model_enc(input logic [3:0] d);
        logic       b [1:7];
        int         dp [4];
        logic [6:0] c;
        dp = '{3, 5, 6, 7};
        for (int i = 0; i < 4; i++) b[dp[i]] = d[i];
        for (int p = 1; p <= 4; p *= 2) begin
            b[p] = 1'b0;
            for (int i = 0; i < 4; i++) if ((dp[i] & p) != 0) b[p] = b[p] ^ d[i];
        end
        for (int i = 1; i <= 7; i++) c[i-1] = b[i];
        return c;
    endfunction

    function automatic logic [6:0] model_flip(input logic [6:0] c, input int pos);
        logic [6:0] r;
        r = c;
        if (pos != 0) r[pos-1] = ~r[pos-1];
        return r;
    endfunction

    task automatic run_word(input logic [3:0] d, input logic inj, input logic [2:0] p,
                            input logic [6:0] ecode, input logic [2:0] esyn,
                            input int hold, input logic kv, input logic clr);
        int n, lat;
        n = 0;
        while (!cur_ready && n < 20) begin @(negedge clk); n++; end
        chk("in_ready_idle", cur_ready, 1);
        in_valid = 1'b1; in_data = d; inject_en = inj; err_pos = p;
        lat = 0;
        do begin
            @(negedge clk);
            if (!kv) in_valid = 1'b0;
            lat++;
        end while (!cur_valid && lat < 20);
        chk("latency", lat, 3);
        for (int h = 0; h <= hold; h++) begin
            chk("out_valid", cur_valid, 1);
            chk("out_code", cur_code, ecode);
            chk("out_syndrome", cur_syn, esyn);
            chk("out_data", cur_data, d);
            chk("out_mismatch", cur_mm, 0);
            chk("hold_in_ready", cur_ready, 0);
            chk("hold_word_cnt", cur_word, ew);
            if (h < hold) @(negedge clk);
        end
        out_ready = 1'b1; clr_cnt = clr;
        @(negedge clk);
        out_ready = 1'b0; clr_cnt = 1'b0; in_valid = 1'b0;
        if (clr) begin
            ew = 0; ec = 0; ee = 0;
        end else begin
            if (ew < emax) ew++;
            if (esyn != 0 && ec < emax) ec++;
        end
        chk("word_cnt", cur_word, ew);
        chk("corr_cnt", cur_corr, ec);
        chk("err_cnt", cur_err, ee);
        chk("post_hs_busy", cur_busy, 0);
        chk("post_hs_out_valid", cur_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] d;
        logic       inj;
        logic [2:0] p;
        logic [6:0] ec7;
        int         apos;
        sel = 1'b0; rst_n = 1'b0; rst_a_n = 1'b0;
        in_valid = 1'b0; inject_en = 1'b0; out_ready = 1'b0; clr_cnt = 1'b0;
        in_data = '0; err_pos = '0;
        ew = 0; ec = 0; ee = 0; emax = 65535;
        vt[0] = '{4'b1011, 1'b0, 3'd0, 0,  1'b0, 7'b1010101, 3'd0};
        vt[1] = '{4'b1011, 1'b1, 3'd5, 0,  1'b0, 7'b1000101, 3'd5};
        vt[2] = '{4'b1011, 1'b1, 3'd3, 10, 1'b1, 7'b1010001, 3'd3};
        vt[3] = '{4'b0000, 1'b1, 3'd0, 0,  1'b0, 7'b0000000, 3'd0};
        vt[4] = '{4'b1111, 1'b0, 3'd6, 2,  1'b0, 7'b1111111, 3'd0};
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_code", out_code, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_word_cnt", word_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++)
            run_word(vt[i].d, vt[i].inj, vt[i].p, vt[i].code, vt[i].syn, vt[i].hold, vt[i].kv, 1'b0);
        for (int i = 0; i < 20; i++) begin
            d   = 4'($urandom_range(0, 15));
            inj = 1'($urandom_range(0, 1));
            p   = 3'($urandom_range(0, 7));
            ec7 = model_flip(model_enc(d), inj ? int'(p) : 0);
            run_word(d, inj, p, ec7, inj ? p : 3'd0, $urandom_range(0, 2), 1'b0, 1'b0);
        end
        in_valid = 1'b1; in_data = 4'b0110; inject_en = 1'b1; err_pos = 3'd2;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("busy_in_dec", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_word_cnt", word_cnt, 0);
        chk("midrst_out_code", out_code, 0);
        ew = 0; ec = 0; ee = 0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_no_output", out_valid, 0);
        run_word(4'b1001, 1'b1, 3'd7, model_flip(model_enc(4'b1001), 7), 3'd7, 0, 1'b0, 1'b0);
        run_word(4'b0101, 1'b1, 3'd1, model_flip(model_enc(4'b0101), 1), 3'd1, 0, 1'b0, 1'b1);
        sel = 1'b1; rst_n = 1'b0; rst_a_n = 1'b1;
        ew = 0; ec = 0; ee = 0; emax = 7;
        @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            apos = (k % 7) + 1;
            d    = 4'($urandom_range(0, 15));
            p    = 3'($urandom_range(0, 7));
            run_word(d, 1'b1, p, model_flip(model_enc(d), apos), 3'(apos), 0, 1'b0, 1'b0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
